fetch_req_ctrl: RTL and testbench

//  Instruction-fetch request controller. Issues sram-like fetch requests to the inst side of the
//  AXI bridge, tracks the single outstanding fetch, buffers the returned instruction until the

---
 rtl/fetch_req_ctrl_pkg.sv | 26 ++
 rtl/fetch_req_ctrl_inst_buf.sv | 36 +++
 rtl/fetch_req_ctrl.sv | 141 ++++++++++++++
 tb/tb_fetch_req_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_req_ctrl_pkg.sv
// Shared definitions for the instruction-fetch request controller:
// one-hot fetch state codes, bus constants and the buffered-entry layout.
package fetch_req_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_WAIT = 4'b0100,
    S_HOLD = 4'b1000
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF    = 32'h1c00_0000;
  localparam logic [1:0]  SRAM_SIZE_WORD  = 2'd2;
  localparam logic [3:0]  SRAM_WSTRB_NONE = 4'h0;

  typedef struct packed {
    logic        excp;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_req_ctrl_inst_buf.sv
// One-entry buffer holding the fetched instruction until decode takes it.
// Load has priority over clear so a redirect can land directly on a new
// (exception) entry in the same cycle it kills the old one.
module fetch_inst_buf
  import fetch_req_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic         accept_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  // Capture, invalidate or hand off the buffered instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end else if (clear_i || accept_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_req_ctrl.sv
// Instruction-fetch request controller: one outstanding sram-like request,
// one-entry result buffer, stale-response discard after a redirect.
// Optional build macro: FETCH_ALIGN_CHK_EN (misaligned pc raises ADEF
// through fs_excp instead of issuing a request).
//
//  state | meaning
//  IDLE  | just out of reset, request starts next cycle
//  REQ   | req/addr driven, waiting for addr_ok
//  WAIT  | request accepted, waiting for data_ok
//  HOLD  | instruction buffered, waiting for decode
module fetch_req_ctrl
  import fetch_req_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        ds_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_excp,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q;
  logic         req_q;
  logic         discard_q;

  logic         go_req;
  logic         misalign;
  logic         buf_load, buf_clear, buf_accept;
  fetch_entry_t buf_in, buf_out;

  // Next pc and the "leaving toward REQ" condition shared by FSM and buffer.
  always_comb begin
    pc_d = pc_q;
    if (flush)
      pc_d = flush_pc;
    else if (state_q == S_HOLD && ds_allowin)
      pc_d = pc_q + 32'd4;
    go_req = (state_q == S_IDLE)
           | ((state_q == S_WAIT) & inst_sram_data_ok & (discard_q | flush))
           | ((state_q == S_HOLD) & (flush | ds_allowin));
  end

`ifdef FETCH_ALIGN_CHK_EN
  assign misalign = go_req & pc_misaligned(pc_d);
`else
  assign misalign = 1'b0;
`endif

  // Buffer control: real data only when the response is neither stale nor
  // overtaken by a redirect in the same cycle.
  always_comb begin
    buf_load   = ((state_q == S_WAIT) & inst_sram_data_ok & ~discard_q & ~flush)
               | misalign;
    buf_clear  = (state_q == S_HOLD) & flush;
    buf_accept = (state_q == S_HOLD) & ds_allowin;
    buf_in     = misalign ? '{excp: 1'b1, pc: pc_d, inst: 32'h0}
                          : '{excp: 1'b0, pc: pc_q, inst: inst_sram_rdata};
  end

  // Fetch FSM with registered request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= 32'h0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_REQ: begin
          // Request is never retracted; a redirect only marks its reply stale.
          discard_q <= discard_q | flush;
          if (inst_sram_addr_ok) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            discard_q <= 1'b0;
            if (!(discard_q || flush))
              state_q <= S_HOLD;
          end else begin
            discard_q <= discard_q | flush;
          end
        end
        S_IDLE, S_HOLD: ;
        default: state_q <= S_IDLE;
      endcase
      if (go_req) begin
        if (misalign) begin
          state_q <= S_HOLD;
          req_q   <= 1'b0;
        end else begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          addr_q  <= pc_d;
        end
      end
    end
  end

  fetch_inst_buf u_buf (
    .clk      (clk),
    .reset    (reset),
    .load_i   (buf_load),
    .clear_i  (buf_clear),
    .accept_i (buf_accept),
    .entry_i  (buf_in),
    .valid_o  (fs_valid),
    .entry_o  (buf_out)
  );

  assign fs_pc           = buf_out.pc;
  assign fs_inst         = buf_out.inst;
  assign fs_excp         = buf_out.excp;
  assign inst_sram_req   = req_q;
  assign inst_sram_addr  = addr_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram_wstrb = SRAM_WSTRB_NONE;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed bench for fetch_req_ctrl: the bench plays the inst bridge,
// expected decode-side results go through a scoreboard queue.
module tb_fetch_req_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush, ds_allowin;
  logic [31:0] flush_pc;
  logic        fs_valid, fs_excp;
  logic [31:0] fs_pc, fs_inst;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_hs    = 0;

  fetch_req_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .ds_allowin        (ds_allowin),
    .fs_valid          (fs_valid),
    .fs_pc             (fs_pc),
    .fs_inst           (fs_inst),
    .fs_excp           (fs_excp),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && inst_sram_req && inst_sram_addr_ok) n_hs++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("fs_pc", fs_pc, e.pc);
      chk("fs_inst", fs_inst, e.inst);
      chk("fs_excp", 32'(fs_excp), 32'd0);
    end
  endtask

  // Hold addr_ok low for 'stall' cycles, checking req/addr stay put, then accept.
  task automatic accept_req(input int stall, input logic [31:0] exp_addr);
    for (int i = 0; i < stall; i++) begin
      chk("req_hold", 32'(inst_sram_req), 32'd1);
      chk("addr_hold", inst_sram_addr, exp_addr);
      tick();
    end
    chk("req_on", 32'(inst_sram_req), 32'd1);
    chk("req_addr", inst_sram_addr, exp_addr);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    chk("req_off", 32'(inst_sram_req), 32'd0);
  endtask

  // Return data 'lat' cycles after acceptance; the result is expected on fs_*.
  task automatic respond(input int lat, input logic [31:0] data, input logic [31:0] pc);
    for (int i = 1; i < lat; i++) begin
      chk("wait_no_valid", 32'(fs_valid), 32'd0);
      tick();
    end
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = data;
    sb.push_back('{pc: pc, inst: data});
    tick();
    inst_sram_data_ok = 1'b0;
    chk("valid_up", 32'(fs_valid), 32'd1);
    pop_check();
  endtask

  initial begin
    int hs0;
    logic [31:0] inst_hold;
    reset = 1'b1; flush = 1'b0; flush_pc = 32'h0; ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    repeat (3) tick();
    chk("rst_valid", 32'(fs_valid), 32'd0);
    chk("rst_req", 32'(inst_sram_req), 32'd0);
    chk("rst_addr", inst_sram_addr, 32'h0);
    chk("rst_fs_pc", fs_pc, 32'h0);
    chk("rst_fs_inst", fs_inst, 32'h0);
    chk("rst_excp", 32'(fs_excp), 32'd0);
    chk("tie_size", 32'(inst_sram_size), 32'd2);
    chk("tie_wr_wstrb_wdata", {inst_sram_wdata[27:0], inst_sram_wstrb} | 32'(inst_sram_wr), 32'h0);

    // 1: basic fetch, data 3 cycles after accept, decode ready
    reset = 1'b0;
    ds_allowin = 1'b1;
    tick();
    accept_req(0, 32'h1c00_0000);
    respond(3, 32'h0280_0000, 32'h1c00_0000);
    tick();
    chk("t1_valid_1cyc", 32'(fs_valid), 32'd0);
    chk("t1_next_req", 32'(inst_sram_req), 32'd1);
    chk("t1_next_addr", inst_sram_addr, 32'h1c00_0004);

    // 2: addr_ok stalled 5 cycles
    hs0 = n_hs;
    accept_req(5, 32'h1c00_0004);
    chk("t2_one_hs", 32'(n_hs - hs0), 32'd1);
    respond(2, 32'h0000_0013, 32'h1c00_0004);
    tick();
    chk("t2_next_addr", inst_sram_addr, 32'h1c00_0008);

    // 3: redirect while WAIT, stale data dropped
    accept_req(0, 32'h1c00_0008);
    tick();
    flush = 1'b1; flush_pc = 32'h1c00_0100;
    tick();
    flush = 1'b0;
    chk("t3_no_req", 32'(inst_sram_req), 32'd0);
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdead_beef;
    tick();
    inst_sram_data_ok = 1'b0;
    chk("t3_valid_low", 32'(fs_valid), 32'd0);
    chk("t3_req", 32'(inst_sram_req), 32'd1);
    chk("t3_addr", inst_sram_addr, 32'h1c00_0100);

    // 4: redirect in REQ before addr_ok, no retraction
    tick();
    flush = 1'b1; flush_pc = 32'h1c00_0200;
    tick();
    flush = 1'b0;
    accept_req(1, 32'h1c00_0100);
    tick();
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbad0_0001;
    tick();
    inst_sram_data_ok = 1'b0;
    chk("t4_valid_low", 32'(fs_valid), 32'd0);
    chk("t4_req", 32'(inst_sram_req), 32'd1);
    chk("t4_addr", inst_sram_addr, 32'h1c00_0200);

    // 5: decode stalls in HOLD, then flush wins over ds_allowin
    ds_allowin = 1'b0;
    accept_req(0, 32'h1c00_0200);
    respond(1, 32'h1234_5678, 32'h1c00_0200);
    inst_hold = fs_inst;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_hold_valid", 32'(fs_valid), 32'd1);
      chk("t5_hold_inst", fs_inst, 32'h1234_5678);
      chk("t5_no_req", 32'(inst_sram_req), 32'd0);
    end
    flush = 1'b1; flush_pc = 32'h1c00_0300; ds_allowin = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_valid", 32'(fs_valid), 32'd0);
    chk("t5_flush_req", 32'(inst_sram_req), 32'd1);
    chk("t5_flush_addr", inst_sram_addr, 32'h1c00_0300);

`ifdef FETCH_ALIGN_CHK_EN
    // 6: misaligned redirect target raises ADEF without a request
    accept_req(0, 32'h1c00_0300);
    flush = 1'b1; flush_pc = 32'h1c00_0102; ds_allowin = 1'b0;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h5555_5555;
    tick();
    flush = 1'b0; inst_sram_data_ok = 1'b0;
    chk("t6_req", 32'(inst_sram_req), 32'd0);
    chk("t6_valid", 32'(fs_valid), 32'd1);
    chk("t6_excp", 32'(fs_excp), 32'd1);
    chk("t6_pc", fs_pc, 32'h1c00_0102);
    chk("t6_inst", fs_inst, 32'h0);
    ds_allowin = 1'b1;
`endif

    // reset mid-operation
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_req", 32'(inst_sram_req), 32'd0);
    chk("mid_rst_addr", inst_sram_addr, 32'h0);
    chk("mid_rst_valid", 32'(fs_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_addr", inst_sram_addr, 32'h1c00_0000);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
